// File: rtl/spi_responder_pkg.sv
// Shared defaults and state encodings for the SPI responder.
package spi_responder_pkg;
  localparam int CMD_W_DEF   = 16;
  localparam int DATA_W_DEF  = 32;
  localparam int SYNC_STAGES = 2;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CMD  = 2'd1;
  localparam logic [1:0] ST_DATA = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;
endpackage

// File: rtl/spi_responder_sync_edge.sv
// Multi-flop synchronizer with rise/fall strobes taken from the synced level
// and its one-cycle-delayed copy.
module spi_sync_edge
  import spi_responder_pkg::*;
#(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic _rst,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);
  // sr[SYNC_STAGES-1] is the synced level, sr[SYNC_STAGES] its delayed copy
  logic [SYNC_STAGES:0] sr;

  always_ff @(posedge clk or negedge _rst) begin
    if (!_rst) sr <= {(SYNC_STAGES+1){RESET_VAL}};
    else       sr <= {sr[SYNC_STAGES-1:0], d};
  end

  assign q    = sr[SYNC_STAGES-1];
  assign rise =  sr[SYNC_STAGES-1] & ~sr[SYNC_STAGES];
  assign fall = ~sr[SYNC_STAGES-1] &  sr[SYNC_STAGES];
endmodule

// File: rtl/spi_responder.sv
// SPI mode-0 responder: oversampled bus, 16-bit command phase followed by a
// 32-bit full-duplex data phase.
module spi_responder
  import spi_responder_pkg::*;
#(
  parameter int CMD_W  = CMD_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              _rst,
  input  logic              sclk_i,
  input  logic              _cs_i,
  input  logic              mosi_i,
  output logic              miso_o,
  output logic              miso_oe,
  input  logic [DATA_W-1:0] tx_data_i,
  output logic              tx_ack_o,
  output logic [CMD_W-1:0]  cmd_o,
  output logic              cmd_valid_o,
  output logic [DATA_W-1:0] rx_data_o,
  output logic              rx_valid_o,
  output logic              abort_o,
  output logic              busy_o
);
  logic sclk_q_unused, sclk_rise, sclk_fall;
  logic cs_q, cs_rise, cs_fall_unused;
  logic mosi_q, mosi_rise_unused, mosi_fall_unused;

  spi_sync_edge #(.RESET_VAL(1'b0)) u_sclk (
    .clk(clk), ._rst(_rst), .d(sclk_i), .q(sclk_q_unused), .rise(sclk_rise), .fall(sclk_fall));
  spi_sync_edge #(.RESET_VAL(1'b1)) u_cs (
    .clk(clk), ._rst(_rst), .d(_cs_i), .q(cs_q), .rise(cs_rise), .fall(cs_fall_unused));
  spi_sync_edge #(.RESET_VAL(1'b0)) u_mosi (
    .clk(clk), ._rst(_rst), .d(mosi_i), .q(mosi_q), .rise(mosi_rise_unused), .fall(mosi_fall_unused));

  // After reset, wait for the synchronizer to carry real pin samples and for
  // _cs to be seen high, so a frame already in flight is ignored.
  logic [1:0] flush;
  logic       armed;

  always_ff @(posedge clk or negedge _rst) begin
    if (!_rst) begin
      flush <= '0;
      armed <= 1'b0;
    end else begin
      if (flush != 2'd3) flush <= flush + 2'd1;
      armed <= armed | ((flush == 2'd3) & cs_q);
    end
  end

  logic [1:0]        state;
  logic [5:0]        bitcnt;
  logic [CMD_W-2:0]  cmd_shift;
  logic [DATA_W-2:0] rx_shift;
  logic [DATA_W-1:0] tx_shift;
  logic              leave;

  // A _cs rise ends any active frame and beats a coincident SCLK rise.
  assign leave = (state != ST_IDLE) & cs_rise;

  always_ff @(posedge clk or negedge _rst) begin
    if (!_rst) begin
      state       <= ST_IDLE;
      bitcnt      <= '0;
      cmd_shift   <= '0;
      rx_shift    <= '0;
      tx_shift    <= '0;
      miso_o      <= 1'b0;
      miso_oe     <= 1'b0;
      busy_o      <= 1'b0;
      tx_ack_o    <= 1'b0;
      cmd_o       <= '0;
      cmd_valid_o <= 1'b0;
      rx_data_o   <= '0;
      rx_valid_o  <= 1'b0;
      abort_o     <= 1'b0;
    end else begin
      tx_ack_o    <= 1'b0;
      cmd_valid_o <= 1'b0;
      rx_valid_o  <= 1'b0;
      abort_o     <= 1'b0;
      if (leave) begin
        abort_o <= (state != ST_DONE);
        state   <= ST_IDLE;
        bitcnt  <= '0;
        miso_o  <= 1'b0;
        miso_oe <= 1'b0;
        busy_o  <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            // Level test keeps a fall that lands while still leaving DONE.
            if (armed && !cs_q) begin
              tx_shift <= tx_data_i;
              tx_ack_o <= 1'b1;
              busy_o   <= 1'b1;
              miso_oe  <= 1'b1;
              miso_o   <= 1'b0;
              bitcnt   <= '0;
              state    <= ST_CMD;
            end
          end
          ST_CMD: begin
            if (sclk_rise) begin
              cmd_shift <= {cmd_shift[CMD_W-3:0], mosi_q};
              bitcnt    <= bitcnt + 6'd1;
              if (bitcnt == 6'(CMD_W-1)) begin
                cmd_o       <= {cmd_shift, mosi_q};
                cmd_valid_o <= 1'b1;
                bitcnt      <= '0;
                state       <= ST_DATA;
              end
            end
          end
          ST_DATA: begin
            if (sclk_fall) begin
              miso_o   <= tx_shift[DATA_W-1];
              tx_shift <= {tx_shift[DATA_W-2:0], 1'b0};
            end
            if (sclk_rise) begin
              rx_shift <= {rx_shift[DATA_W-3:0], mosi_q};
              bitcnt   <= bitcnt + 6'd1;
              if (bitcnt == 6'(DATA_W-1)) begin
                rx_data_o  <= {rx_shift, mosi_q};
                rx_valid_o <= 1'b1;
                bitcnt     <= '0;
                miso_o     <= 1'b0;
                state      <= ST_DONE;
              end
            end
          end
          default: miso_o <= 1'b0;
        endcase
      end
    end
  end
endmodule
